// File: rtl/seq_muldiv.sv
// seq_muldiv: sequential RISC-V style multiply/divide unit.
//   Multiplies use an iterative shift-add datapath (or a single-cycle
//   multiplier when FAST_MUL != 0); divides use restoring division.
//   Operands are reduced to magnitudes on acceptance and the sign is
//   restored in a final FIX cycle.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  request handshake (op, a, b latched on acceptance)
//   op                   000 MUL 001 MULH 010 MULHSU 011 MULHU
//                        100 DIV 101 DIVU 110 REM  111 REMU
//   flush                synchronous abort, returns to IDLE
//   out_valid/out_ready  result handshake, result held stable in DONE
//   busy                 high whenever the unit is not IDLE
module seq_muldiv #(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;      // final result must be negated
    logic [XLEN-1:0]   hi_q, hi_d;        // product high half / remainder
    logic [XLEN-1:0]   lo_q, lo_d;        // multiplier->product low / quotient
    logic [XLEN-1:0]   b_q, b_d;          // multiplicand / divisor magnitude
    logic [XLEN-1:0]   result_q, result_d;

    // ---------------- acceptance-time operand decode ----------------
    logic              is_div, signed_a, signed_b, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, acc_neg;
    logic [XLEN-1:0]   special_res;

    assign is_div   = op[2];
    assign signed_a = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    assign signed_b = is_div ? ~op[0] : (op[1:0] == 2'b01);
    assign sa       = signed_a & a[XLEN-1];
    assign sb       = signed_b & b[XLEN-1];
    assign mag_a    = sa ? -a : a;
    assign mag_b    = sb ? -b : b;
    // Remainder follows the dividend sign; everything else the product of signs.
    assign acc_neg  = (is_div && op[1]) ? sa : (sa ^ sb);

    assign div_zero = is_div && (b == '0);
    assign div_ovf  = is_div && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    // Divide by zero: quotient all-ones, remainder = a.
    // Signed overflow: quotient = a (most negative), remainder = 0.
    assign special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    // Single-cycle multiplier, only reachable when FAST_MUL != 0.
    logic [2*XLEN-1:0] fast_mag, fast_prod;
    logic [XLEN-1:0]   fast_res;
    assign fast_mag  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign fast_prod = (sa ^ sb) ? -fast_mag : fast_mag;
    assign fast_res  = (op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];

    // ---------------- iterative step datapath ----------------
    // Shift-add: add multiplicand to the high half when the current
    // multiplier bit is set, then shift {carry, hi, lo} right by one.
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

    // Restoring divide: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_sub;
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_sub   = div_shift[XLEN-1:0] - b_q;   // exact whenever div_ge

    // ---------------- FIX-cycle sign restore and field select ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_sel, div_fix, fix_res;
    assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign div_sel  = op_q[1] ? hi_q : lo_q;
    assign div_fix  = neg_q ? -div_sel : div_sel;
    assign fix_res  = op_q[2] ? div_fix
                    : (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;

        if (flush) begin
            // Flush outranks both acceptance and the result handshake.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d  = op;
                        neg_d = acc_neg;
                        hi_d  = '0;
                        lo_d  = mag_a;
                        b_d   = mag_b;
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            state_d  = DONE;
                        end else if (FAST_MUL != 0 && !is_div) begin
                            result_d = fast_res;
                            state_d  = DONE;
                        end else begin
                            cnt_d   = CW'(XLEN);
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (op_q[2]) begin
                        hi_d = div_ge ? div_sub : div_shift[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], div_ge};
                    end else begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = FIX;
                end
                FIX: begin
                    result_d = fix_res;
                    state_d  = DONE;
                end
                DONE: begin
                    // No acceptance here: a new request waits for IDLE.
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Scoreboard bench for seq_muldiv: expected results and latencies are
// queued when a request is driven and compared when out_valid appears.
module tb_seq_muldiv;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                           OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                           OP_REM = 3'b110, OP_REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0, busy;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0, result;

    logic        f_in_valid = 1'b0, f_in_ready, f_flush = 1'b0, f_out_valid, f_out_ready = 1'b0, f_busy;
    logic [2:0]  f_op = '0;
    logic [31:0] f_a = '0, f_b = '0, f_result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    seq_muldiv #(.XLEN(32), .FAST_MUL(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    seq_muldiv #(.XLEN(32), .FAST_MUL(1)) dut_fast (
        .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready), .op(f_op),
        .a(f_a), .b(f_b), .flush(f_flush), .out_valid(f_out_valid), .out_ready(f_out_ready),
        .result(f_result), .busy(f_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model built on the simulator's own signed/unsigned arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int          sx = x;
        int          sy = y;
        longint      lx = sx;
        longint      ly = sy;
        logic [63:0] p;
        case (o)
            OP_MUL:    begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            OP_MULH:   begin p = lx * ly;                 return p[63:32]; end
            OP_MULHSU: begin p = lx * longint'({32'b0, y}); return p[63:32]; end
            OP_MULHU:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            OP_DIV:    if (y == 0) return 32'hFFFF_FFFF;
                       else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                       else return sx / sy;
            OP_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            OP_REM:    if (y == 0) return x;
                       else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                       else return sx % sy;
            default:   return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit fast);
        if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
        if (!o[2] && fast) return 1;
        return 33;
    endfunction

    task automatic drive_req(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int k = 0;
        while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
        check("in_ready_before_req", in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!out_valid && n < 100);
        check({tag, "_latency"}, n, lat_q.pop_front());
        check(tag, result, exp_q.pop_front());
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_ack", {busy, out_valid}, 2'b00);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_q.push_back(model(o, x, y));
        lat_q.push_back(exp_lat(o, x, y, 1'b0));
        drive_req(o, x, y);
        wait_result(tag);
        ack();
    endtask

    task automatic fast_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        exp_q.push_back(model(o, x, y));
        lat_q.push_back(exp_lat(o, x, y, 1'b1));
        f_op = o; f_a = x; f_b = y; f_in_valid = 1'b1;
        @(posedge clk); #1;
        f_in_valid = 1'b0;
        do begin @(posedge clk); #1; n++; end while (!f_out_valid && n < 100);
        check({tag, "_latency"}, n, lat_q.pop_front());
        check(tag, f_result, exp_q.pop_front());
        f_out_ready = 1'b1;
        @(posedge clk); #1;
        f_out_ready = 1'b0;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen = 0;
        repeat (cycles) begin @(posedge clk); #1; if (out_valid) seen++; end
        check(tag, seen, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] held;

        // Reset values while rst is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", result, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        run_op("mul_7_neg3",   OP_MUL,    32'd7,          32'hFFFF_FFFD);
        run_op("mulhsu_m1",    OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op("mulhu_m1",     OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op("mulh_m1",      OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op("div_m7_2",     OP_DIV,    32'hFFFF_FFF9,  32'd2);
        run_op("rem_m7_2",     OP_REM,    32'hFFFF_FFF9,  32'd2);
        run_op("divu_100_7",   OP_DIVU,   32'd100,        32'd7);
        run_op("remu_100_7",   OP_REMU,   32'd100,        32'd7);
        run_op("div_ovf",      OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF);
        run_op("rem_ovf",      OP_REM,    32'h8000_0000,  32'hFFFF_FFFF);
        run_op("divu_by0",     OP_DIVU,   32'd5,          32'd0);
        run_op("remu_by0",     OP_REMU,   32'd5,          32'd0);
        run_op("div_by0",      OP_DIV,    32'hFFFF_FFF0,  32'd0);
        run_op("rem_by0",      OP_REM,    32'hFFFF_FFF0,  32'd0);
        run_op("mulh_mixed",   OP_MULH,   32'h8000_0000,  32'h7FFF_FFFF);
        run_op("rem_pos_neg",  OP_REM,    32'd17,         32'hFFFF_FFFB);

        // Randomized mix over all ops with corner-heavy operands.
        for (int i = 0; i < 24; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 7));
            run_op("rand", o, pick(), pick());
        end

        // Hold in DONE with out_ready low: everything stays put.
        exp_q.push_back(model(OP_DIVU, 32'd1000, 32'd3));
        lat_q.push_back(exp_lat(OP_DIVU, 32'd1000, 32'd3, 1'b0));
        drive_req(OP_DIVU, 32'd1000, 32'd3);
        wait_result("hold_first");
        held = result;
        in_valid = 1'b1;
        op = OP_MUL; a = 32'd2; b = 32'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_result", result, held);
            check("hold_in_ready", in_ready, 0);
        end
        // Handshake with a request offered on the same edge: it must not be taken.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("ack_no_accept_busy", busy, 0);
        check("ack_in_ready", in_ready, 1);
        check("ack_out_valid", out_valid, 0);

        // Flush in cycle 10 of a DIV.
        drive_req(OP_DIV, 32'd123456, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        check("flush_pre_busy", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", {busy, in_ready}, 2'b01);
        expect_quiet("flush_no_out_valid", 40);

        // Request offered together with flush is dropped.
        in_valid = 1'b1; flush = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", busy, 0);

        // Flush while DONE waits for out_ready.
        drive_req(OP_DIVU, 32'd9, 32'd0);
        @(posedge clk); #1;
        check("done_before_flush", out_valid, 1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        check("flush_from_done", {out_valid, busy}, 2'b00);

        // Asynchronous reset in the middle of a MUL.
        run_op("pre_rst_mul", OP_MUL, 32'd1234, 32'd5678);
        drive_req(OP_MUL, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_result", result, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        expect_quiet("midrst_no_out_valid", 40);
        run_op("post_rst_mulhu", OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);

        // Single-cycle multiplier instance.
        fast_op("fast_mul_3x4",  OP_MUL,    32'd3,         32'd4);
        fast_op("fast_mulhsu",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        fast_op("fast_mulh",     OP_MULH,   32'h8000_0000, 32'h8000_0000);
        fast_op("fast_divu",     OP_DIVU,   32'd100,       32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_muldiv.md
SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand and result width (SHALL be >= 8).
REQ-002 Parameter FAST_MUL, default 0; 1 SHALL select a single-cycle multiplier, 0 an iterative one.
REQ-003 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  unit can accept a request.
REQ-007 op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 a, b  in  XLEN  operands (a = rs1/dividend, b = rs2/divisor).
REQ-009 flush  in  1  synchronous abort of any in-flight operation.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  consumer takes the result.
REQ-012 result  out  XLEN  operation result.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY, FIX and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; acceptance SHALL occur on an edge where in_valid & in_ready, latching op, a and b.
REQ-016 On acceptance of DIV/REM with b==0, or of DIV/REM with a==most-negative and b==all-ones, the FSM SHALL go directly to DONE (out_valid in cycle 1, acceptance = cycle 0).
REQ-017 On acceptance of a multiply with FAST_MUL=1, the FSM SHALL go directly to DONE.
REQ-018 On all other acceptances, the FSM SHALL enter BUSY with iteration counter = XLEN.
REQ-019 Operands SHALL be converted to magnitudes on acceptance per op signedness: MULH, DIV and REM both signed; MULHSU a signed, b unsigned; the rest unsigned.
REQ-020 BUSY SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle and decrement the counter.
REQ-021 When the counter reaches 0, the FSM SHALL enter FIX; FIX SHALL negate the product, quotient or remainder as required, select the result field, and go to DONE (out_valid in cycle XLEN+1).
REQ-022 Result fields: MUL low XLEN bits; MULH, MULHSU and MULHU the high XLEN bits of the 2*XLEN product.
REQ-023 Quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero: DIV and DIVU SHALL return all-ones; REM and REMU SHALL return a.
REQ-025 Signed overflow: DIV SHALL return the most-negative value; REM SHALL return 0.
REQ-026 In DONE, out_valid=1 and result SHALL stay stable until out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-027 A new request SHALL NOT be accepted in the same cycle as a DONE handshake.
REQ-028 flush=1 SHALL force IDLE on the next edge from any state, clearing out_valid.
REQ-029 flush SHALL have priority over acceptance and over the out_ready handshake; a request offered during flush is not accepted.
REQ-030 The result register SHALL be written only on transitions into DONE.

Reset
REQ-031 While rst=1, state SHALL be IDLE, out_valid=0, busy=0, in_ready=1, result=0, and the counter and datapath registers SHALL be 0.
REQ-032 Assertion of rst mid-operation SHALL discard the operation immediately; no out_valid SHALL follow.

Verification (XLEN=32, FAST_MUL=0 unless stated)
REQ-033 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid first high in cycle 33.
REQ-034 MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-035 DIV a=0xFFFFFFF9, b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU with the same operands -> 2.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, each in cycle 1; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5, each in cycle 1.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-038 Flush in cycle 10 of a DIV -> IDLE at the next edge with no out_valid; rst pulse mid-MUL -> reset values immediately; FAST_MUL=1 MUL 3*4 -> 12 in cycle 1.
